cbus_arbiter: RTL and testbench

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter_if.sv | 28 ++
 rtl/cbus_arbiter.sv | 80 ++++++++
 tb/tb_cbus_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cbus_arbiter_if.sv
// CBus bundle between the cache-side requesters, the arbiter and the memory-side port.
// Request and response layouts are shared by the arbiter and its clients.
interface cbus_arbiter_if #(parameter int NUM_INPUTS = 2);
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  cbus_req_t  [NUM_INPUTS-1:0] ireqs;
  cbus_resp_t [NUM_INPUTS-1:0] iresps;
  cbus_req_t                   oreq;
  cbus_resp_t                  oresp;

  // arbiter side
  modport slave (input ireqs, output iresps, output oreq, input oresp);
  // requesters plus memory side, as seen by the environment
  modport master (output ireqs, input iresps, input oreq, output oresp);
endinterface

// File: rtl/cbus_arbiter.sv
// Round-robin CBus arbiter: one owner at a time is forwarded to the memory side
// until a ready&&last beat, with one IDLE cycle between transactions.
module cbus_arbiter #(
  parameter  int NUM_INPUTS = 2,
  localparam int GW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  cbus_arbiter_if.slave bus,
  output logic [GW-1:0] grant_o,
  output logic [3:0]    beat_cnt_o,
  output logic          busy_o
);
  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [3:0]    beat_q, beat_d;
  logic          found;
  int            idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_INPUTS - 1);
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    found        = 1'b0;
    idx          = 0;
    bus.oreq     = '0;
    bus.iresps   = '0;
    case (state_q)
      IDLE: begin
        // scan starts just after the previous owner
        for (int k = 1; k <= NUM_INPUTS; k++) begin
          idx = (int'(last_grant_q) + k) % NUM_INPUTS;
          if (!found && bus.ireqs[idx].valid) begin
            found   = 1'b1;
            grant_d = GW'(idx);
          end
        end
        if (found) begin
          state_d = BUSY;
          beat_d  = '0;
        end
      end
      BUSY: begin
        // gated by reset so nothing leaks out while an abandoned burst is torn down
        if (!reset) begin
          bus.oreq            = bus.ireqs[grant_q];
          bus.iresps[grant_q] = bus.oresp;
        end
        if (bus.oresp.ready) beat_d = beat_q + 4'd1;
        if (bus.oresp.ready && bus.oresp.last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_o    = grant_q;
  assign beat_cnt_o = beat_q;
  assign busy_o     = (state_q == BUSY);
endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: expected owners are queued as requests are raised
// and popped when the arbiter starts forwarding.
module tb_cbus_arbiter;
  localparam int N = 2;
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN16 = 4'd15;

  logic       clk = 1'b0;
  logic       reset;
  logic       grant;
  logic [3:0] beat_cnt;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  cbus_arbiter_if #(.NUM_INPUTS(N)) bus ();

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .grant_o(grant), .beat_cnt_o(beat_cnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_resps(input string tag, input int owner);
    for (int i = 0; i < N; i++)
      if (i != owner) chk(tag, 128'(bus.iresps[i]), 128'(0));
  endtask

  task automatic set_req(input int p, input logic wr, input logic [31:0] a, input logic [3:0] l,
                         input logic [7:0] s, input logic [63:0] d);
    bus.ireqs[p].valid    = 1'b1;
    bus.ireqs[p].is_write = wr;
    bus.ireqs[p].addr     = a;
    bus.ireqs[p].len      = l;
    bus.ireqs[p].strobe   = s;
    bus.ireqs[p].data     = d;
  endtask

  // Called at a negedge while idle; runs one transaction of nbeats beats.
  // Optional events (-1 = none) at a given beat index.
  task automatic txn(input int nbeats, input int raise0_at, input int drop_at,
                     input int stall_at, input int reset_at);
    int w = 0;
    int g;
    do begin @(negedge clk); w++; end while (!busy && w < 8);
    chk("grant_latency", 128'(w), 128'(1));
    if (!busy) return;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 128'(0), 128'(1));
      return;
    end
    g = exp_q.pop_front();
    chk("grant_idx", 128'(grant), 128'(g));
    chk("oreq_addr", 128'(bus.oreq.addr), 128'(bus.ireqs[g].addr));
    for (int b = 0; b < nbeats; b++) begin
      if (b == raise0_at) begin bus.ireqs[0].valid = 1'b1; exp_q.push_back(0); end
      if (b == drop_at) bus.ireqs[g].valid = 1'b0;
      if (b == stall_at) begin
        for (int s = 0; s < 10; s++) begin
          bus.oresp = '0;
          bus.oresp.last = 1'b1;
          #1;
          chk("stall_busy", 128'(busy), 128'(1));
          chk("stall_grant", 128'(grant), 128'(g));
          chk("stall_beats", 128'(beat_cnt), 128'(b[3:0]));
          chk("stall_oreq", 128'(bus.oreq), 128'(bus.ireqs[g]));
          chk("stall_ready", 128'(bus.iresps[g].ready), 128'(0));
          @(posedge clk); @(negedge clk);
        end
      end
      if (b == reset_at) begin
        reset = 1'b1;
        bus.oresp = '0;
        bus.oresp.ready = 1'b1;
        #1;
        chk("rst_oreq_valid", 128'(bus.oreq.valid), 128'(0));
        chk_idle_resps("rst_iresps", -1);
        @(posedge clk); @(negedge clk);
        bus.oresp = '0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_oreq_valid2", 128'(bus.oreq.valid), 128'(0));
        return;
      end
      bus.oresp.ready = 1'b1;
      bus.oresp.last  = (b == nbeats - 1);
      bus.oresp.data  = {$urandom, $urandom};
      #1;
      chk("beat_busy", 128'(busy), 128'(1));
      chk("beat_grant", 128'(grant), 128'(g));
      chk("beat_cnt", 128'(beat_cnt), 128'(b[3:0]));
      chk("beat_oreq", 128'(bus.oreq), 128'(bus.ireqs[g]));
      chk("beat_iresp", 128'(bus.iresps[g]), 128'(bus.oresp));
      chk_idle_resps("beat_other_iresp", g);
      @(posedge clk); @(negedge clk);
    end
    bus.oresp = '0;
    #1;
    chk("end_idle", 128'(busy), 128'(0));
    chk("end_oreq_valid", 128'(bus.oreq.valid), 128'(0));
    chk_idle_resps("end_iresps", -1);
  endtask

  initial begin
    reset = 1'b1;
    bus.ireqs = '0;
    bus.oresp = '0;
    repeat (2) @(negedge clk);
    chk("reset_oreq", 128'(bus.oreq), 128'(0));
    chk_idle_resps("reset_iresps", -1);
    chk("reset_busy", 128'(busy), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 128'(busy), 128'(0));
    chk("post_reset_grant", 128'(grant), 128'(0));
    chk("post_reset_oreq_valid", 128'(bus.oreq.valid), 128'(0));

    // tie from reset, then alternation while both keep requesting
    set_req(0, 1'b0, 32'h0000_0100, MLEN16, 8'hFF, 64'h0);
    set_req(1, 1'b0, 32'h0000_0200, MLEN16, 8'hFF, 64'h0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    for (int t = 0; t < 4; t++) begin
      if (t == 3) bus.ireqs[0].valid = 1'b0;
      txn(16, -1, -1, -1, -1);
    end
    bus.ireqs = '0;

    // no preemption: port 0 raises valid at beat 3 of port 1's burst
    set_req(1, 1'b0, 32'h0000_0340, MLEN16, 8'hFF, 64'h0);
    bus.ireqs[0].addr = 32'h0000_0480;
    exp_q.push_back(1);
    txn(16, 3, -1, -1, -1);
    bus.ireqs[1].valid = 1'b0;
    txn(1, -1, -1, -1, -1);
    bus.ireqs = '0;

    // uncached single-beat write from port 1
    set_req(1, 1'b1, 32'h0000_1008, MLEN1, 8'h0F, 64'h1122334455667788);
    exp_q.push_back(1);
    txn(1, -1, -1, -1, -1);
    bus.ireqs = '0;

    // owner drops valid mid-burst, arbiter keeps it until last
    set_req(0, 1'b0, 32'h0000_2000, MLEN16, 8'hFF, 64'h0);
    exp_q.push_back(0);
    txn(4, -1, 1, -1, -1);
    bus.ireqs = '0;

    // stall: ready low for 10 cycles at beat 2
    set_req(1, 1'b1, 32'h0000_3000, MLEN16, 8'hAA, 64'hDEAD_BEEF_0000_0001);
    exp_q.push_back(1);
    txn(6, -1, -1, 2, -1);
    bus.ireqs = '0;

    // reset at beat 7, then a fresh port 1 request
    set_req(1, 1'b0, 32'h0000_4000, MLEN16, 8'hFF, 64'h0);
    exp_q.push_back(1);
    txn(16, -1, -1, -1, 7);
    reset = 1'b0;
    exp_q.push_back(1);
    txn(1, -1, -1, -1, -1);
    bus.ireqs = '0;

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
